tone_period_meter: RTL and testbench
====================================

Name: tone_period_meter

Overview:
- Receive-side counterpart of the DDS tone source: it recovers tone period from a sampled sinusoid, the inverse of the DDS phase_inc-to-sine mapping.
- Detects rising zero crossings with hysteresis and counts accepted samples between crossings.
- Averages 2^AVG_LOG2 consecutive periods and reports the mean period with a valid pulse.
- Sits after the DDS or fir_filter output in the signal chain and gives benches and on-chip monitors a frequency readback.

Parameters:
- DATA_WIDTH, 16: width of signed two's-complement input sample.
- CNT_WIDTH, 24: width of per-period counter and of period_o.
- HYST, 256: hysteresis threshold magnitude, positive, less than 2^(DATA_WIDTH-1).
- AVG_LOG2, 2: log2 of the number of periods averaged per result (0 means no averaging).
- TIMEOUT, 65535: accepted-sample count without a rising crossing that declares loss of tone; must be less than 2^CNT_WIDTH-1.

Ports:
- clk_i, input, 1: single clock.
- arst_i, input, 1: asynchronous reset, active-high.
- en_i, input, 1: sample strobe; data_i is accepted only when high.
- data_i, input, DATA_WIDTH: signed input sample.
- period_o, output, CNT_WIDTH: averaged period in accepted samples, truncated (floor).
- valid_o, output, 1: one-cycle pulse when period_o updates.
- locked_o, output, 1: high while periods are being measured.
- timeout_o, output, 1: one-cycle pulse on loss of tone.

Behaviour:
- Reset (async, arst_i=1):
  - period_o=0, valid_o=0, locked_o=0, timeout_o=0.
  - Hysteresis state = LOW; FSM = ARM; counters and accumulator = 0.
  - Assertion mid-measurement discards all partial results immediately.
- Nothing advances when en_i=0:
  - counters, hysteresis state and FSM hold;
  - valid_o and timeout_o still deassert after one cycle.
- Hysteresis comparator, on each accepted sample:
  - data_i >= +HYST sets state HIGH;
  - data_i <= -HYST sets state LOW;
  - otherwise the state holds.
  - A rising crossing is an accepted sample that moves the state LOW->HIGH. The comparison is signed.
- Period counter:
  - Increments on every accepted sample.
  - On a rising-crossing sample, the captured period = counter+1, i.e. samples since the previous crossing sample, inclusive of the current one. The counter then loads 0.
  - Saturates at 2^CNT_WIDTH-1; TIMEOUT normally fires first.
- FSM states:
  - ARM: wait for the first rising crossing; no period is captured. On a crossing, clear the counter and go to MEASURE with locked_o=0.
  - MEASURE: on each crossing, add the captured period to the accumulator (width CNT_WIDTH+AVG_LOG2) and increment the period index.
    - When the index wraps at 2^AVG_LOG2, register period_o = accumulator + current period, shifted right by AVG_LOG2.
    - On the same clock, set valid_o=1 for one cycle and set locked_o=1; the accumulator and index clear.
    - Latency: period_o and valid_o appear on the clock edge that samples the completing crossing, visible the next cycle.
  - Timeout: in MEASURE or ARM, if the counter reaches TIMEOUT on an accepted sample, pulse timeout_o, clear locked_o, clear the accumulator and index, and go to ARM. period_o holds its last value.
- Simultaneous events:
  - A crossing on the same sample that would reach TIMEOUT counts as a crossing; no timeout fires.
  - valid_o and timeout_o are never high together.
- Arithmetic: the accumulator never overflows because each period is at most TIMEOUT. Division is by shift only; no rounding.

Decomposition:
- Package tone_meter_pkg:
  - state enum (ARM, MEASURE);
  - function computing the accumulator width from CNT_WIDTH and AVG_LOG2.
- One natural sub-module: hyst_cross_detect, covering the comparator, hysteresis state register and rising-crossing pulse, gated by en_i. Counter, accumulator and FSM stay in the top.

Test Plan:
- Square tone, period 40: data_i = +1000 for 20 samples then -1000 for 20, en_i=1, defaults.
  - Expect the first valid_o 4 periods after the first rising crossing, with period_o=40 and locked_o=1.
  - Expect valid_o every 160 cycles thereafter.
- Sub-hysteresis noise: data_i alternates +100/-100 for 2000 cycles after a lock.
  - No valid_o.
  - timeout_o pulses once, exactly TIMEOUT accepted samples after the last crossing; locked_o drops and period_o holds 40.
- en_i gating: en_i high every other cycle, same tone in accepted samples.
  - period_o=40; valid_o spacing 320 clocks.
- Non-integer averaging: DDS tone with phase_inc 2000, 16-bit phase, period ≈32.768 samples, AVG_LOG2=2.
  - period_o in {32,33}, never outside.
  - Check with AVG_LOG2=0: each period_o in {32,33}.
- Reset mid-measure: assert arst_i asynchronously (between clock edges) during the third period of the first lock.
  - All outputs go to 0 immediately.
  - After release, the first valid_o requires a fresh ARM crossing plus 4 periods.
- Boundary: set TIMEOUT=50 and a tone of period exactly 50.
  - The crossing wins on the coinciding sample: no timeout_o, period_o=50.
  - With period 51: timeout_o pulses and no valid_o.

Source files
------------

// File: rtl/tone_meter_pkg.sv
// Shared types and sizing helpers for the tone period meter.
package tone_meter_pkg;

    typedef enum logic {
        ARM     = 1'b0,
        MEASURE = 1'b1
    } meter_state_e;

    // Accumulator holds up to 2^avg_log2 periods of cnt_w bits each.
    function automatic int acc_width(input int cnt_w, input int avg_log2);
        return cnt_w + avg_log2;
    endfunction

endpackage

// File: rtl/hyst_cross_detect.sv
// Signed hysteresis comparator; flags the accepted sample that moves the state LOW->HIGH.
module hyst_cross_detect #(
    parameter int DATA_WIDTH = 16,
    parameter int HYST       = 256
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic                         rise_o
);

    localparam logic signed [DATA_WIDTH-1:0] POS_TH = DATA_WIDTH'(HYST);
    localparam logic signed [DATA_WIDTH-1:0] NEG_TH = DATA_WIDTH'(-HYST);

    logic above, below, high_q;

    assign above = (data_i >= POS_TH);
    assign below = (data_i <= NEG_TH);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            high_q <= 1'b0;
        end else if (en_i) begin
            if (above)      high_q <= 1'b1;
            else if (below) high_q <= 1'b0;
        end
    end

    assign rise_o = en_i & above & ~high_q;

endmodule

// File: rtl/tone_period_meter.sv
// Measures tone period in accepted samples between rising crossings and reports
// the floor mean over 2^AVG_LOG2 periods, with loss-of-tone detection.
module tone_period_meter
    import tone_meter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 24,
    parameter int HYST       = 256,
    parameter int AVG_LOG2   = 2,
    parameter int TIMEOUT    = 65535
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    output logic [CNT_WIDTH-1:0]         period_o,
    output logic                         valid_o,
    output logic                         locked_o,
    output logic                         timeout_o
);

    localparam int ACC_W = acc_width(CNT_WIDTH, AVG_LOG2);
    localparam int IDX_W = AVG_LOG2 + 1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT - 1);

    meter_state_e         state_q, state_d;
    logic                 rise, hit_to, capture, complete;
    logic [CNT_WIDTH-1:0] cnt_q, cur_period;
    logic [ACC_W-1:0]     acc_q, acc_sum;
    logic [IDX_W-1:0]     idx_q;

    hyst_cross_detect #(
        .DATA_WIDTH(DATA_WIDTH),
        .HYST      (HYST)
    ) u_cross (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .en_i  (en_i),
        .data_i(data_i),
        .rise_o(rise)
    );

    // A crossing on the sample that would reach TIMEOUT takes precedence.
    assign hit_to     = en_i & ~rise & (cnt_q == TO_LAST);
    assign cur_period = cnt_q + 1'b1;
    assign acc_sum    = acc_q + ACC_W'(cur_period);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) state_q <= ARM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARM:     if (rise)   state_d = MEASURE;
            MEASURE: if (hit_to) state_d = ARM;
            default:             state_d = ARM;
        endcase
    end

    always_comb begin
        capture  = 1'b0;
        complete = 1'b0;
        if (state_q == MEASURE) begin
            capture  = rise;
            complete = rise & (idx_q == IDX_LAST);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            period_o  <= '0;
            valid_o   <= 1'b0;
            locked_o  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
            if (en_i) begin
                if (rise)                cnt_q <= '0;
                else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            end
            if (hit_to) begin
                acc_q     <= '0;
                idx_q     <= '0;
                locked_o  <= 1'b0;
                timeout_o <= 1'b1;
            end else if (complete) begin
                period_o <= CNT_WIDTH'(acc_sum >> AVG_LOG2);
                valid_o  <= 1'b1;
                locked_o <= 1'b1;
                acc_q    <= '0;
                idx_q    <= '0;
            end else if (capture) begin
                acc_q <= acc_sum;
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter: square tones, noise, gating, reset, DDS tone, timeout boundary.
module tb_tone_period_meter;

    localparam int DW = 16;
    localparam int CW = 24;

    logic                 clk_i = 1'b0;
    logic                 arst_i;
    logic                 en_i;
    logic signed [DW-1:0] data_i;

    logic [CW-1:0] m_period, a0_period, t_period;
    logic          m_valid, m_locked, m_timeout;
    logic          a0_valid, a0_locked, a0_timeout;
    logic          t_valid, t_locked, t_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    tone_period_meter #(.TIMEOUT(1000)) u_m (
        .clk_i(clk_i), .arst_i(arst_i), .en_i(en_i), .data_i(data_i),
        .period_o(m_period), .valid_o(m_valid), .locked_o(m_locked), .timeout_o(m_timeout)
    );

    tone_period_meter #(.AVG_LOG2(0), .TIMEOUT(1000)) u_a0 (
        .clk_i(clk_i), .arst_i(arst_i), .en_i(en_i), .data_i(data_i),
        .period_o(a0_period), .valid_o(a0_valid), .locked_o(a0_locked), .timeout_o(a0_timeout)
    );

    tone_period_meter #(.TIMEOUT(50)) u_t (
        .clk_i(clk_i), .arst_i(arst_i), .en_i(en_i), .data_i(data_i),
        .period_o(t_period), .valid_o(t_valid), .locked_o(t_locked), .timeout_o(t_timeout)
    );

    // Square wave: high for the first ceil(per/2) samples of each period.
    function automatic logic signed [DW-1:0] sq(input int k, input int per);
        return ((k % per) < (per - per / 2)) ? 16'sd1000 : -16'sd1000;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        arst_i = 1'b1;
        en_i   = 1'b0;
        data_i = '0;
        tick();
        tick();
        arst_i = 1'b0;
        tick();
    endtask

    initial begin
        logic [15:0] ph;
        int          mv, av;

        // Reset state
        arst_i = 1'b1;
        en_i   = 1'b0;
        data_i = '0;
        tick();
        tick();
        chkn("rst_period",  m_period,  24'd0);
        chk1("rst_valid",   m_valid,   1'b0);
        chk1("rst_locked",  m_locked,  1'b0);
        chk1("rst_timeout", m_timeout, 1'b0);
        arst_i = 1'b0;
        tick();
        chk1("rst_rel_valid", m_valid, 1'b0);

        // Square tone, period 40: ARM crossing at k=0, valid every 160 samples
        en_i = 1'b1;
        for (int k = 0; k < 800; k++) begin
            data_i = sq(k, 40);
            tick();
            chk1("sq_valid",  m_valid,  (k > 0) && (k % 160 == 0));
            chk1("sq_locked", m_locked, k >= 160);
            chk1("sq_a0_valid", a0_valid, (k > 0) && (k % 40 == 0));
            chk1("sq_t_timeout", t_timeout, 1'b0);
            if ((k > 0) && (k % 160 == 0)) chkn("sq_period", m_period, 24'd40);
            if ((k > 0) && (k % 40 == 0))  chkn("sq_a0_period", a0_period, 24'd40);
        end

        // Sub-hysteresis noise: last crossing at k=760, counter at 39 on entry
        for (int n = 0; n < 2000; n++) begin
            data_i = (n % 2 == 0) ? 16'sd100 : -16'sd100;
            tick();
            chk1("nz_timeout", m_timeout, n == 960);
            chk1("nz_valid",   m_valid,   1'b0);
            chk1("nz_locked",  m_locked,  n < 960);
            chk1("nz_t_timeout", t_timeout, n == 10);
        end
        chkn("nz_period_hold", m_period, 24'd40);

        // en_i gating: accepted samples on even clocks, junk data on idle clocks
        for (int c = 0; c < 1600; c++) begin
            en_i   = (c % 2 == 0);
            data_i = en_i ? sq(c / 2, 40) : 16'sd30000;
            tick();
            chk1("en_valid", m_valid, (c % 2 == 0) && (c / 2 > 0) && ((c / 2) % 160 == 0));
            if (m_valid) chkn("en_period", m_period, 24'd40);
        end

        // Asynchronous reset in the third period after lock
        do_reset();
        en_i = 1'b1;
        for (int k = 0; k <= 460; k++) begin
            data_i = sq(k, 40);
            if (k == 250) begin
                chk1("rm_locked_pre", m_locked, 1'b1);
                chkn("rm_period_pre", m_period, 24'd40);
                #2 arst_i = 1'b1;
                #1;
                chkn("rm_period_rst",  m_period,  24'd0);
                chk1("rm_valid_rst",   m_valid,   1'b0);
                chk1("rm_locked_rst",  m_locked,  1'b0);
                chk1("rm_timeout_rst", m_timeout, 1'b0);
            end
            if (k == 265) arst_i = 1'b0;
            tick();
            if (k < 250) begin
                chk1("rm_valid_a", m_valid, k == 160);
            end else if (k >= 265) begin
                chk1("rm_valid_b",  m_valid,  k == 440);
                chk1("rm_locked_b", m_locked, k >= 440);
                if (k == 440) chkn("rm_period_b", m_period, 24'd40);
            end
        end

        // DDS tone, phase_inc 2000 of 65536: periods of 32 or 33 samples
        do_reset();
        en_i = 1'b1;
        ph = '0;
        mv = 0;
        av = 0;
        for (int s = 0; s < 2000; s++) begin
            data_i = DW'($rtoi(20000.0 * $sin(6.283185307179586 * real'(ph) / 65536.0)));
            ph = ph + 16'd2000;
            tick();
            if (m_valid) begin
                mv++;
                chk1("dds_avg_range", (m_period == 24'd32) || (m_period == 24'd33), 1'b1);
            end
            if (a0_valid) begin
                av++;
                chk1("dds_a0_range", (a0_period == 24'd32) || (a0_period == 24'd33), 1'b1);
            end
        end
        chk1("dds_avg_count", mv >= 14, 1'b1);
        chk1("dds_a0_count",  av >= 58, 1'b1);
        chk1("dds_no_timeout", m_timeout | a0_timeout, 1'b0);

        // Boundary, TIMEOUT=50: period 50 crossing wins on the coinciding sample
        do_reset();
        en_i = 1'b1;
        for (int k = 0; k < 400; k++) begin
            data_i = sq(k, 50);
            tick();
            chk1("b50_timeout", t_timeout, 1'b0);
            chk1("b50_valid",   t_valid,   k == 200);
            if (k == 200) chkn("b50_period", t_period, 24'd50);
        end

        // Period 51: timeout one sample before every crossing, never a result
        do_reset();
        en_i = 1'b1;
        for (int k = 0; k <= 400; k++) begin
            data_i = sq(k, 51);
            tick();
            chk1("b51_timeout", t_timeout, (k % 51) == 50);
            chk1("b51_valid",   t_valid,   1'b0);
            chk1("b51_locked",  t_locked,  1'b0);
        end
        chkn("b51_period_hold", t_period, 24'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
